// File: rtl/plot_sink.sv
// plot_sink: receiving end of the pixel-plot stream from the screen drawers.
// Clips each {x, y, color} beat against the screen and converts it to a
// linear frame-buffer address (y*SCREEN_W + x). Accepted pixels are queued
// in a small circular FIFO and drained into the frame-buffer write port
// under a ready handshake, so drawers never stall.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   plot_in           pixel beat valid
//   x_in, y_in        pixel column / row
//   color_in          pixel color
//   mem_ready         frame buffer accepts a write this cycle
//   mem_we            write request (FIFO non-empty)
//   mem_addr/mem_data head entry address / color
//   fifo_count        FIFO occupancy, 0..DEPTH
//   clip_count        out-of-bounds beats discarded (saturating)
//   drop_count        in-bounds beats lost to a full FIFO (saturating)
//   overflow          sticky flag, set on the first drop
module plot_sink #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       plot_in,
  input  logic [8:0]                 x_in,
  input  logic [7:0]                 y_in,
  input  logic [2:0]                 color_in,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [16:0]                mem_addr,
  output logic [2:0]                 mem_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 clip_count,
  output logic [7:0]                 drop_count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  // FIFO storage: {addr[16:0], color[2:0]} per entry
  logic [19:0]   buf_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    clip_q, clip_d;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic          in_bounds;
  logic [16:0]   row_base;
  logic [16:0]   addr;
  logic          full;
  logic          pop;
  logic          push;

  // Address arithmetic kept at 17 bits; the row product never exceeds
  // the frame size, so the cast only drops unused upper zeros.
  always_comb begin
    row_base  = 17'(32'(y_in) * SCREEN_W);
    addr      = row_base + {8'b0, x_in};
    in_bounds = (32'(x_in) < SCREEN_W) && (32'(y_in) < SCREEN_H);
  end

  always_comb begin
    full = (count_q == (AW+1)'(DEPTH));
    pop  = (count_q != '0) && mem_ready;
    // A full FIFO still accepts a beat when the head retires in the same cycle.
    push = reset_n && plot_in && in_bounds && (!full || pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    clip_d   = clip_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    if (plot_in) begin
      if (!in_bounds) begin
        if (clip_q != '1) clip_d = clip_q + 8'd1;
      end else if (full && !pop) begin
        if (drop_q != '1) drop_d = drop_q + 8'd1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      clip_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      clip_q   <= clip_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= {addr, color_in};
  end

  always_comb begin
    mem_we     = (count_q != '0);
    mem_addr   = buf_q[rd_ptr_q][19:3];
    mem_data   = buf_q[rd_ptr_q][2:0];
    fifo_count = count_q;
    clip_count = clip_q;
    drop_count = drop_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_plot_sink.sv
module tb_plot_sink;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        plot_in;
  logic [8:0]  x_in;
  logic [7:0]  y_in;
  logic [2:0]  color_in;
  logic        mem_ready;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic [3:0]  fifo_count;
  logic [7:0]  clip_count;
  logic [7:0]  drop_count;
  logic        overflow;

  plot_sink #(.SCREEN_W(320), .SCREEN_H(240), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .plot_in    (plot_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .color_in   (color_in),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .fifo_count (fifo_count),
    .clip_count (clip_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected {addr, color} in write order
  logic [19:0] sb_q[$];
  int          mcount = 0;
  int          mclip  = 0;
  int          mdrop  = 0;
  logic        movf   = 1'b0;
  int          writes = 0;
  logic [16:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input int x, input int y, input int c, input logic rdy);
    plot_in   = p;
    x_in      = 9'(x);
    y_in      = 8'(y);
    color_in  = 3'(c);
    mem_ready = rdy;
  endtask

  // One clock: predict with the inputs currently applied, check the write
  // port before the edge, check registered state 1 time unit after it.
  task automatic tick();
    bit          pop;
    bit          inb;
    bit          push;
    logic [19:0] e;
    pop  = 0;
    push = 0;
    if (!reset_n) begin
      sb_q.delete();
      mcount = 0;
      mclip  = 0;
      mdrop  = 0;
      movf   = 1'b0;
    end else begin
      pop = (mcount != 0) && mem_ready;
      chk("mem_we", 32'(mem_we), 32'(mcount != 0));
      if (pop) begin
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(e[19:3]));
          chk("mem_data", 32'(mem_data), 32'(e[2:0]));
        end
        last_addr = mem_addr;
        writes++;
      end
      if (plot_in) begin
        inb = (int'(x_in) < 320) && (int'(y_in) < 240);
        if (!inb) begin
          if (mclip < 255) mclip++;
        end else if (mcount < DEPTH || pop) begin
          push = 1;
          sb_q.push_back({17'(int'(y_in) * 320 + int'(x_in)), color_in});
        end else begin
          if (mdrop < 255) mdrop++;
          movf = 1'b1;
        end
      end
      mcount = mcount + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
    chk("fifo_count", 32'(fifo_count), 32'(mcount));
    chk("clip_count", 32'(clip_count), 32'(mclip));
    chk("drop_count", 32'(drop_count), 32'(mdrop));
    chk("overflow",   32'(overflow),   32'(movf));
  endtask

  task automatic drain(input int n);
    drive(1'b0, 0, 0, 0, 1'b1);
    repeat (n) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b1, 400, 0, 1, 1'b0);   // beat during reset must count nowhere
    tick();
    reset_n = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  int w0;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);

    // Single plot
    drive(1'b1, 10, 20, 5, 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("single_we", 32'(mem_we), 32'd1);
    chk("single_addr", 32'(mem_addr), 32'd6410);
    chk("single_data", 32'(mem_data), 32'd5);
    tick();
    chk("single_we_after", 32'(mem_we), 32'd0);
    chk("single_count_after", 32'(fifo_count), 32'd0);

    // Bounds
    w0 = writes;
    drive(1'b1, 320, 0, 7, 1'b1);   tick();
    drive(1'b1, 0, 240, 7, 1'b1);   tick();
    drive(1'b1, 319, 239, 7, 1'b1); tick();
    drain(3);
    chk("bounds_clip", 32'(clip_count), 32'd2);
    chk("bounds_writes", 32'(writes - w0), 32'd1);
    chk("bounds_addr", 32'(last_addr), 32'd76799);

    // Overflow: 9 plots into a stalled FIFO
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i, 0, i, 1'b0);
      tick();
    end
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    w0 = writes;
    drain(9);
    chk("ovf_writes", 32'(writes - w0), 32'd8);
    chk("ovf_last_addr", 32'(last_addr), 32'd7);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous pop
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 1, 2, 1'b0);
      tick();
    end
    drive(1'b1, 9, 1, 3, 1'b1);
    tick();
    chk("fullpop_count", 32'(fifo_count), 32'd8);
    chk("fullpop_drop", 32'(drop_count), 32'd1);
    drain(9);
    chk("fullpop_last", 32'(last_addr), 32'd329);

    // Wrap-around with random ready
    do_reset();
    w0 = writes;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i * 7, 3 + i, i, (mcount >= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)));
      tick();
    end
    drain(12);
    chk("wrap_writes", 32'(writes - w0), 32'd20);
    chk("wrap_clip", 32'(clip_count), 32'd0);
    chk("wrap_drop", 32'(drop_count), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 100 + i, 50, 4, 1'b0);
      tick();
    end
    chk("pre_reset_count", 32'(fifo_count), 32'd5);
    do_reset();
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_clip", 32'(clip_count), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    drive(1'b1, 1, 1, 6, 1'b0);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("fresh_we", 32'(mem_we), 32'd1);
    chk("fresh_addr", 32'(mem_addr), 32'd321);
    drain(2);
    chk("fresh_last", 32'(last_addr), 32'd321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
